// File: rtl/apb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// apb_bridge_pkg : shared state encoding for the APB master bridge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb_bridge_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_SETUP  = c_ST_SETUP,
        ST_ACCESS = c_ST_ACCESS,
        ST_RESP   = c_ST_RESP
    } state_t;

endpackage

`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_if : command/response handshake plus APB3 bus signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ---------------------------------------------------------------------------
// apb_wait_timer : saturating wait-state counter with expiry flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            logic w_unused;
            assign w_unused = ^{clk, rst, i_clear, i_enable};
            assign o_expire = 1'b0;
        end else begin : g_timeout
            localparam int c_CW = $clog2(TIMEOUT + 1);
            localparam logic [c_CW-1:0] c_MAX  = c_CW'(TIMEOUT);
            localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

            logic [c_CW-1:0] r_count;

            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_count <= '0;
                end else if (i_enable && (r_count != c_MAX)) begin
                    r_count <= r_count + c_CW'(1);
                end
            end

            // Fires during the TIMEOUT-th consecutive low cycle so the bridge
            // leaves ACCESS on that same edge.
            assign o_expire = i_enable && (r_count == c_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge : single-outstanding valid/ready to APB3 initiator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  wire logic            PCLK,
    input  wire logic            PRESET,
    apb_master_bridge_if.master  bus
);

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;

    logic w_accept;
    logic w_wait;
    logic w_expire;

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_wait   = (r_state == ST_ACCESS) && !bus.PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (PCLK),
        .rst      (PRESET),
        .i_clear  (w_accept),
        .i_enable (w_wait),
        .o_expire (w_expire)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_pwrite    <= bus.cmd_write;
                        r_paddr     <= bus.cmd_addr;
                        r_pwdata    <= bus.cmd_write ? bus.cmd_wdata : '0;
                        r_psel      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A completing slave takes priority over a coincident timeout.
                    if (bus.PREADY) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err     <= bus.PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (w_expire) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge : self-checking bench for apb_master_bridge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_master_bridge;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut0 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus0)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       slverr;
        int         nwait;
        int         delay;
        logic [7:0] e_rdata;
        logic       e_err;
        logic       e_to;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Reference: a slave stalling TIMEOUT or more cycles is aborted after
    // exactly TIMEOUT ACCESS cycles; otherwise ACCESS lasts nwait+1 cycles.
    function automatic void model(input vec_t v, output logic [7:0] rd,
                                  output logic err, output logic to, output int acc);
        if (TO != 0 && v.nwait >= TO) begin
            rd = 8'h00; err = 1'b1; to = 1'b1; acc = TO;
        end else begin
            rd = v.wr ? 8'h00 : v.rdata; err = v.slverr; to = 1'b0; acc = v.nwait + 1;
        end
    endfunction

    // Entered and left at a negedge with the bridge idle.
    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] mrd;
        logic       me, mt;
        int         acc;
        logic [7:0] ew;
        model(v, mrd, me, mt, acc);
        ew = v.wr ? v.wdata : 8'h00;

        chk("idle_cmd_ready", idx, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_wdata = 8'($urandom);

        chk("setup_ctl", idx, 32'({bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid}), 32'(4'b1000));
        chk("setup_bus", idx, 32'({bus.PWRITE, bus.PADDR, bus.PWDATA}), 32'({v.wr, v.addr, ew}));

        for (int k = 0; k < acc; k++) begin
            @(negedge PCLK);
            chk("access_ctl", idx, 32'({bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid}), 32'(4'b1100));
            chk("access_bus", idx, 32'({bus.PWRITE, bus.PADDR, bus.PWDATA}), 32'({v.wr, v.addr, ew}));
            bus.PREADY  = (k >= v.nwait);
            bus.PRDATA  = bus.PREADY ? v.rdata  : 8'($urandom);
            bus.PSLVERR = bus.PREADY ? v.slverr : 1'($urandom);
        end
        @(negedge PCLK);
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = 8'($urandom);

        for (int d = 0; d <= v.delay; d++) begin
            chk("resp_ctl", idx, 32'({bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid}), 32'(4'b0001));
            chk("resp_data", idx, 32'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}),
                32'({v.e_rdata, v.e_err, v.e_to}));
            chk("resp_model", idx, 32'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}),
                32'({mrd, me, mt}));
            chk("resp_hold_bus", idx, 32'({bus.PWRITE, bus.PADDR, bus.PWDATA}), 32'({v.wr, v.addr, ew}));
            if (d < v.delay) begin
                bus.rsp_ready = 1'b0;
                @(negedge PCLK);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
        chk("after_hs", idx, 32'({bus.cmd_ready, bus.rsp_valid, bus.PSEL}), 32'(3'b100));
    endtask

    vec_t tbl [8];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b1, 8'h00, 8'hA5, 8'h00, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h10, 8'h00, 8'h3C, 1'b0, 3, 0, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h22, 8'h5A, 8'h77, 1'b1, 1, 1, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h7F, 8'h00, 8'hFF, 1'b1, 0, 0, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h33, 8'h00, 8'h99, 1'b0, 4, 0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 8'h44, 8'hE1, 8'h00, 1'b0, 3, 0, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h81, 8'h00, 8'h81, 1'b0, 2, 5, 8'h81, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'hFE, 8'h0F, 8'h00, 1'b1, 9, 2, 8'h00, 1'b1, 1'b1};

        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0;
        bus0.rsp_ready = 1'b0; bus0.PRDATA = '0; bus0.PREADY = 1'b0; bus0.PSLVERR = 1'b0;

        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        chk("reset_outs", 0, 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
                                  bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}), 32'd0);
        chk("reset_rdata", 0, 32'(bus.rsp_rdata), 32'd0);
        chk("reset_cmd_ready", 0, 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] mrd;
            logic       me, mt;
            int         acc;
            rv.wr     = 1'($urandom);
            rv.addr   = 8'($urandom);
            rv.wdata  = 8'($urandom);
            rv.rdata  = 8'($urandom);
            rv.slverr = 1'($urandom);
            rv.nwait  = int'($urandom_range(0, 6));
            rv.delay  = int'($urandom_range(0, 3));
            model(rv, mrd, me, mt, acc);
            rv.e_rdata = mrd; rv.e_err = me; rv.e_to = mt;
            run_vec(rv, 100 + i);
        end

        // Reset while in ACCESS discards the transfer entirely.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h5E; bus.cmd_wdata = 8'hC3;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("rst_pre_access", 0, 32'({bus.PSEL, bus.PENABLE}), 32'(2'b11));
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("rst_mid_outs", 0, 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
                                    bus.rsp_valid}), 32'd0);
        chk("rst_mid_cmd_ready", 0, 32'(bus.cmd_ready), 32'd1);
        bus.PREADY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            chk("rst_no_rsp", k, 32'({bus.rsp_valid, bus.PSEL, bus.cmd_ready}), 32'(3'b001));
        end
        bus.PREADY = 1'b0;
        rv = '{1'b0, 8'h5E, 8'h00, 8'h42, 1'b0, 1, 0, 8'h42, 1'b0, 1'b0};
        run_vec(rv, 200);

        // TIMEOUT=0 build never aborts a stalled slave.
        bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b0; bus0.cmd_addr = 8'h12;
        @(negedge PCLK);
        bus0.cmd_valid = 1'b0;
        chk("t0_setup", 0, 32'({bus0.PSEL, bus0.PENABLE, bus0.PADDR}), 32'({2'b10, 8'h12}));
        for (int k = 0; k < 100; k++) begin
            @(negedge PCLK);
            chk("t0_stall", k, 32'({bus0.PSEL, bus0.PENABLE, bus0.rsp_valid}), 32'(3'b110));
        end
        bus0.PREADY = 1'b1; bus0.PRDATA = 8'h6D;
        @(negedge PCLK);
        bus0.PREADY = 1'b0;
        chk("t0_resp", 0, 32'({bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err, bus0.rsp_timeout}),
            32'({1'b1, 8'h6D, 2'b00}));
        bus0.rsp_ready = 1'b1;
        @(negedge PCLK);
        bus0.rsp_ready = 1'b0;
        chk("t0_idle", 0, 32'({bus0.cmd_ready, bus0.rsp_valid}), 32'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected completion within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
